// File: rtl/usbfs_pkg.sv
// Shared types for the USB full-speed IN endpoint: per-buffer state and PID toggle values.
package usbfs_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_SENDING = 2'd3
    } buf_state_t;

    localparam logic DATA0 = 1'b0;
    localparam logic DATA1 = 1'b1;

    // Buffer pointers are one bit wide; a single-buffer build keeps them at 0.
    function automatic logic ptr_next(input logic p, input int n_buf);
        return (n_buf > 1) ? ~p : 1'b0;
    endfunction

endpackage

// File: rtl/usbfs_tx_bank.sv
// One packet buffer of the IN endpoint: byte storage, byte count and buffer state.
module usbfs_tx_bank
    import usbfs_pkg::*;
#(
    parameter int MAX_PKT  = 8,
    parameter int IDX_W    = $clog2(MAX_PKT),
    parameter int NBYTES_W = $clog2(MAX_PKT + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_wr,
    input  logic [7:0]          i_wrData,
    input  logic                i_commit,
    input  logic                i_zlp,
    input  logic                i_start,
    input  logic                i_ack,
    input  logic                i_abort,
    input  logic [IDX_W-1:0]    i_rdIdx,
    output logic [1:0]          o_state,
    output logic [NBYTES_W-1:0] o_count,
    output logic [7:0]          o_rdByte
);

    buf_state_t          r_state;
    logic [NBYTES_W-1:0] r_count;
    logic [7:0]          r_mem [MAX_PKT];

    // Storage is never reset; the state/count pair decides what is meaningful.
    always_ff @(posedge i_clk) begin
        if (i_wr && !i_flush)
            r_mem[r_count[IDX_W-1:0]] <= i_wrData;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BUF_EMPTY;
            r_count <= '0;
        end else if (i_flush) begin
            r_state <= BUF_EMPTY;
            r_count <= '0;
        end else if (i_wr) begin
            r_count <= r_count + 1'b1;
            r_state <= i_commit ? BUF_FULL : BUF_FILLING;
        end else if (i_zlp) begin
            r_count <= '0;
            r_state <= BUF_FULL;
        end else if (i_start) begin
            r_state <= BUF_SENDING;
        end else if (i_ack) begin
            r_count <= '0;
            r_state <= BUF_EMPTY;
        end else if (i_abort) begin
            r_state <= BUF_FULL;
        end
    end

    assign o_state  = r_state;
    assign o_count  = r_count;
    assign o_rdByte = r_mem[i_rdIdx];

endmodule

// File: rtl/usbfs_endp_tx_pp.sv
// Ping-pong buffered USB FS IN endpoint with toggle, halt and flush handling.
// Optional feature: define USBFS_ENDP_TX_ZLP_EN to append a ZLP after a transfer ending on MAX_PKT.
module usbfs_endp_tx_pp
    import usbfs_pkg::*;
#(
    parameter int MAX_PKT = 8,
    parameter int N_BUF   = 2,
    localparam int IDX_W    = $clog2(MAX_PKT),
    localparam int NBYTES_W = $clog2(MAX_PKT + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_ready,
    input  logic                i_valid,
    input  logic [7:0]          i_data,
    input  logic                i_last,
    input  logic                i_flush,
    input  logic                i_halt,
    input  logic                i_clrHalt,
    output logic                o_etValid,
    output logic                o_etStall,
    output logic                o_etPid,
    output logic [NBYTES_W-1:0] o_etNBytes,
    input  logic                i_etStart,
    input  logic [IDX_W-1:0]    i_etRdIdx,
    output logic [7:0]          o_etRdByte,
    input  logic                i_etAck,
    input  logic                i_etAbort
);

    logic r_head, r_tail, r_toggle, r_halted, r_zlpPend;
    logic [7:0] r_rdByte;

    logic [1:0]          w_state [2];
    logic [NBYTES_W-1:0] w_count [2];
    logic [7:0]          w_rd    [2];

    buf_state_t w_tailState, w_headState;
    logic w_ready, w_accept, w_fullByte, w_commit, w_zlpReq, w_zlpWr;

    assign w_tailState = buf_state_t'(w_state[r_tail]);
    assign w_headState = buf_state_t'(w_state[r_head]);

    assign w_ready    = !r_halted && !r_zlpPend &&
                        (w_tailState == BUF_EMPTY || w_tailState == BUF_FILLING);
    assign w_accept   = w_ready && i_valid;
    assign w_fullByte = (w_count[r_tail] == NBYTES_W'(MAX_PKT - 1));
    assign w_commit   = w_accept && (i_last || w_fullByte);

`ifdef USBFS_ENDP_TX_ZLP_EN
    assign w_zlpReq = w_accept && i_last && w_fullByte;
    assign w_zlpWr  = r_zlpPend && (w_tailState == BUF_EMPTY);
`else
    assign w_zlpReq = 1'b0;
    assign w_zlpWr  = 1'b0;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < N_BUF) begin : g_inst
            usbfs_tx_bank #(.MAX_PKT(MAX_PKT)) u_bank (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_flush  (i_flush),
                .i_wr     (w_accept && (r_tail == 1'(b))),
                .i_wrData (i_data),
                .i_commit (w_commit),
                .i_zlp    (w_zlpWr && (r_tail == 1'(b))),
                .i_start  (i_etStart && (r_head == 1'(b))),
                .i_ack    (i_etAck && (r_head == 1'(b))),
                .i_abort  (i_etAbort && (r_head == 1'(b))),
                .i_rdIdx  (i_etRdIdx),
                .o_state  (w_state[b]),
                .o_count  (w_count[b]),
                .o_rdByte (w_rd[b])
            );
        end else begin : g_tie
            assign w_state[b] = BUF_EMPTY;
            assign w_count[b] = '0;
            assign w_rd[b]    = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_zlpPend <= 1'b0;
        end else if (i_flush) begin
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_zlpPend <= 1'b0;
        end else begin
            if (w_commit || w_zlpWr)
                r_tail <= ptr_next(r_tail, N_BUF);
            if (i_etAck)
                r_head <= ptr_next(r_head, N_BUF);
            if (w_zlpReq)
                r_zlpPend <= 1'b1;
            else if (w_zlpWr)
                r_zlpPend <= 1'b0;
        end
    end

    // Flush leaves halt and toggle alone; halt request beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halted <= 1'b0;
            r_toggle <= DATA0;
        end else if (!i_flush) begin
            if (i_halt)
                r_halted <= 1'b1;
            else if (i_clrHalt)
                r_halted <= 1'b0;
            if (i_clrHalt && !i_halt)
                r_toggle <= DATA0;
            else if (i_etAck)
                r_toggle <= ~r_toggle;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rdByte <= '0;
        else
            r_rdByte <= w_rd[r_head];
    end

    assign o_ready    = w_ready;
    assign o_etValid  = !r_halted && (w_headState == BUF_FULL);
    assign o_etStall  = r_halted;
    assign o_etPid    = r_toggle;
    assign o_etNBytes = w_count[r_head];
    assign o_etRdByte = r_rdByte;

`ifndef SYNTHESIS
    a_start_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        i_etStart |-> o_etValid);
    a_ret_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_etAck || i_etAbort) |-> (w_headState == BUF_SENDING));
    a_ret_excl: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_etAck && i_etAbort));
`endif

endmodule

// File: tb/tb_usbfs_endp_tx_pp.sv
// Self-checking bench for usbfs_endp_tx_pp: vector table, directed corner cases, random vs queue model.
module tb_usbfs_endp_tx_pp;

    localparam int MAX_PKT = 8;
    localparam int N_BUF   = 2;
    localparam int IDX_W   = 3;
    localparam int NBW     = 4;

    logic clk = 1'b0;
    logic rst;
    logic o_ready, i_valid, i_last, i_flush, i_halt, i_clrHalt;
    logic [7:0] i_data, o_etRdByte;
    logic o_etValid, o_etStall, o_etPid, i_etStart, i_etAck, i_etAbort;
    logic [NBW-1:0] o_etNBytes;
    logic [IDX_W-1:0] i_etRdIdx;

    always #5 clk = ~clk;

    usbfs_endp_tx_pp #(.MAX_PKT(MAX_PKT), .N_BUF(N_BUF)) dut (
        .i_clk(clk), .i_rst(rst), .o_ready(o_ready), .i_valid(i_valid),
        .i_data(i_data), .i_last(i_last), .i_flush(i_flush), .i_halt(i_halt),
        .i_clrHalt(i_clrHalt), .o_etValid(o_etValid), .o_etStall(o_etStall),
        .o_etPid(o_etPid), .o_etNBytes(o_etNBytes), .i_etStart(i_etStart),
        .i_etRdIdx(i_etRdIdx), .o_etRdByte(o_etRdByte), .i_etAck(i_etAck),
        .i_etAbort(i_etAbort)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_in();
        i_valid = 0; i_data = 0; i_last = 0; i_flush = 0; i_halt = 0;
        i_clrHalt = 0; i_etStart = 0; i_etAck = 0; i_etAbort = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        i_etRdIdx = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic put(input logic [7:0] d, input logic last);
        i_valid = 1; i_data = d; i_last = last;
        tick();
        i_valid = 0; i_last = 0;
    endtask

    task automatic start_pkt(); i_etStart = 1; tick(); i_etStart = 0; endtask
    task automatic ack_pkt();   i_etAck = 1;   tick(); i_etAck = 0;   endtask

    task automatic rd_chk(input string name, input int idx, input int exp);
        i_etRdIdx = IDX_W'(idx);
        tick();
        chk(name, o_etRdByte, exp);
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last, start, ack, abort, halt, clr;
        logic       e_ready, e_valid, e_stall, e_pid;
        int         e_nb;   // -1: byte count not compared
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic valid, input logic [7:0] data, input logic start,
                        input logic ack, input logic abort, input logic halt, input logic clr,
                        input logic e_ready, input logic e_valid, input logic e_stall,
                        input logic e_pid, input int e_nb);
        vec_t v;
        v.valid = valid; v.data = data; v.last = 1'b0; v.start = start; v.ack = ack;
        v.abort = abort; v.halt = halt; v.clr = clr; v.e_ready = e_ready;
        v.e_valid = e_valid; v.e_stall = e_stall; v.e_pid = e_pid; v.e_nb = e_nb;
        tv.push_back(v);
    endtask

    // Reference model: committed packets as a length queue over a flat byte queue.
    int         plen[$];
    logic [7:0] flat[$];
    logic [7:0] cur[$];
    bit m_halt, m_pid, m_send, m_zpend;

    task automatic model_step(input logic valid, input logic [7:0] d, input logic last,
                              input logic flush, input logic halt, input logic clr,
                              input logic start, input logic ack, input logic abort);
        bit pre_ready, pre_zp;
        int pre_n, n;
        if (flush) begin
            plen.delete(); flat.delete(); cur.delete();
            m_send = 0; m_zpend = 0;
            return;
        end
        pre_n     = plen.size();
        pre_zp    = m_zpend;
        pre_ready = !m_halt && !m_zpend && (pre_n < N_BUF);
        if (start) m_send = 1;
        if (ack) begin
            n = plen.pop_front();
            repeat (n) void'(flat.pop_front());
            m_send = 0;
            m_pid  = !m_pid;
        end
        if (abort) m_send = 0;
        if (halt) m_halt = 1;
        else if (clr) begin m_halt = 0; m_pid = 0; end
        if (pre_ready && valid) begin
            cur.push_back(d);
            if (last || cur.size() == MAX_PKT) begin
`ifdef USBFS_ENDP_TX_ZLP_EN
                if (last && cur.size() == MAX_PKT) m_zpend = 1;
`endif
                plen.push_back(cur.size());
                foreach (cur[k]) flat.push_back(cur[k]);
                cur.delete();
            end
        end
        if (pre_zp && pre_n < N_BUF) begin
            plen.push_back(0);
            m_zpend = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit exp_ready, exp_valid, rd_pend;
        logic [7:0] rd_exp;
        int idx;

        // ---------------- reset state ----------------
        do_reset();
        chk("reset ready", o_ready, 1);
        chk("reset valid", o_etValid, 0);
        chk("reset stall", o_etStall, 0);
        chk("reset pid", o_etPid, 0);
        chk("reset nbytes", o_etNBytes, 0);
        chk("reset rdbyte", o_etRdByte, 0);

        // ---------------- vector table ----------------
        for (int k = 0; k < 8; k++)
            addv(1, 8'hA0 + 8'(k), 0, 0, 0, 0, 0, 1, k == 7, 0, 0, (k == 7) ? 8 : -1);
        addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8);    // start: count held while sending
        addv(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, -1);   // ack: toggle flips
        for (int k = 0; k < 8; k++)
            addv(1, 8'hB0 + 8'(k), 0, 0, 0, 0, 0, 1, k == 7, 0, 1, (k == 7) ? 8 : -1);
        addv(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, -1);   // halt with a full buffer
        addv(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 8);    // clear halt: same packet, DATA0
        addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8);
        addv(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 8);    // abort: retry with same PID
        addv(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 8);
        addv(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, -1);

        foreach (tv[i]) begin
            i_valid = tv[i].valid; i_data = tv[i].data; i_last = tv[i].last;
            i_etStart = tv[i].start; i_etAck = tv[i].ack; i_etAbort = tv[i].abort;
            i_halt = tv[i].halt; i_clrHalt = tv[i].clr;
            tick();
            clear_in();
            chk($sformatf("vec%0d ready", i), o_ready, tv[i].e_ready);
            chk($sformatf("vec%0d valid", i), o_etValid, tv[i].e_valid);
            chk($sformatf("vec%0d stall", i), o_etStall, tv[i].e_stall);
            chk($sformatf("vec%0d pid", i), o_etPid, tv[i].e_pid);
            if (tv[i].e_nb >= 0)
                chk($sformatf("vec%0d nbytes", i), o_etNBytes, tv[i].e_nb);
        end

        // ---------------- 20-byte transfer: 8, 8, 4 ----------------
        do_reset();
        for (int k = 0; k < 16; k++) put(8'(k), 0);
        chk("x20 ready after 16", o_ready, 0);
        chk("x20 p1 valid", o_etValid, 1);
        chk("x20 p1 nbytes", o_etNBytes, 8);
        chk("x20 p1 pid", o_etPid, 0);
        rd_chk("x20 p1 byte3", 3, 3);
        start_pkt(); ack_pkt();
        chk("x20 ready after ack", o_ready, 1);
        chk("x20 p2 valid", o_etValid, 1);
        chk("x20 p2 pid", o_etPid, 1);
        rd_chk("x20 p2 byte5", 5, 13);
        for (int k = 16; k < 20; k++) put(8'(k), k == 19);
        chk("x20 ready both full", o_ready, 0);
        start_pkt(); ack_pkt();
        chk("x20 p3 valid", o_etValid, 1);
        chk("x20 p3 nbytes", o_etNBytes, 4);
        chk("x20 p3 pid", o_etPid, 0);
        rd_chk("x20 p3 byte2", 2, 18);
        start_pkt(); ack_pkt();
        chk("x20 done valid", o_etValid, 0);
        chk("x20 done pid", o_etPid, 1);
        chk("x20 done ready", o_ready, 1);

        // ---------------- transfer ending on MAX_PKT ----------------
        do_reset();
        for (int k = 0; k < 8; k++) put(8'h40 + 8'(k), k == 7);
        chk("zlp p1 valid", o_etValid, 1);
        chk("zlp p1 nbytes", o_etNBytes, 8);
`ifdef USBFS_ENDP_TX_ZLP_EN
        chk("zlp pending ready", o_ready, 0);
        tick();
        chk("zlp queued ready", o_ready, 0);
        start_pkt(); ack_pkt();
        chk("zlp p2 valid", o_etValid, 1);
        chk("zlp p2 nbytes", o_etNBytes, 0);
        chk("zlp p2 pid", o_etPid, 1);
        start_pkt(); ack_pkt();
        chk("zlp done valid", o_etValid, 0);
        chk("zlp done pid", o_etPid, 0);
`else
        chk("nozlp ready", o_ready, 1);
        start_pkt(); ack_pkt();
        chk("nozlp done valid", o_etValid, 0);
        chk("nozlp done pid", o_etPid, 1);
`endif

        // ---------------- reset mid-packet ----------------
        do_reset();
        for (int k = 0; k < 3; k++) put(8'h70 + 8'(k), 0);
        rst = 1; tick(); rst = 0; tick();
        chk("midrst valid", o_etValid, 0);
        chk("midrst ready", o_ready, 1);
        put(8'h5A, 0); put(8'hC3, 1);
        chk("midrst new valid", o_etValid, 1);
        chk("midrst new nbytes", o_etNBytes, 2);
        rd_chk("midrst byte1", 1, 8'hC3);

        // ---------------- random traffic vs model ----------------
        do_reset();
        plen.delete(); flat.delete(); cur.delete();
        m_halt = 0; m_pid = 0; m_send = 0; m_zpend = 0;
        rd_pend = 0; rd_exp = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_ready = !m_halt && !m_zpend && (plen.size() < N_BUF);
            exp_valid = !m_halt && (plen.size() > 0) && !m_send;
            chk("rnd ready", o_ready, exp_ready);
            chk("rnd valid", o_etValid, exp_valid);
            chk("rnd stall", o_etStall, m_halt);
            chk("rnd pid", o_etPid, m_pid);
            if (plen.size() > 0 && (exp_valid || m_send))
                chk("rnd nbytes", o_etNBytes, plen[0]);
            if (rd_pend)
                chk("rnd rdbyte", o_etRdByte, rd_exp);

            clear_in();
            i_valid = ($urandom_range(0, 99) < 70);
            i_data  = 8'($urandom);
            i_last  = ($urandom_range(0, 99) < 8);
            i_flush = ($urandom_range(0, 199) == 0);
            i_halt  = ($urandom_range(0, 199) == 0);
            if (!i_halt)
                i_clrHalt = m_halt ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            if (exp_valid)
                i_etStart = ($urandom_range(0, 1) == 1);
            if (m_send) begin
                idx = $urandom_range(0, 9);
                i_etAck   = (idx < 3);
                i_etAbort = (idx == 3);
                if (i_etAck) i_clrHalt = 0;
            end
            idx = $urandom_range(0, MAX_PKT - 1);
            i_etRdIdx = IDX_W'(idx);
            rd_pend = (plen.size() > 0) && (idx < plen[0]);
            if (rd_pend) rd_exp = flat[idx];

            model_step(i_valid, i_data, i_last, i_flush, i_halt, i_clrHalt,
                       i_etStart, i_etAck, i_etAbort);
            tick();
        end
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
